vga_button_conditioner: RTL and testbench

//  Input-conditioning stage directly upstream of vgadriver.
//  - Cleans raw board buttons East/West/North/South/func_switch: synchronise, debounce.
//  - Emits one-cycle press strobes and auto-repeat movement strobes.
//  - Emits a func_mode level that toggles once per press.

---
 rtl/vga_button_conditioner_pkg.sv | 22 ++
 rtl/vga_button_conditioner_debounce_channel.sv | 60 ++++++
 rtl/vga_button_conditioner.sv | 134 +++++++++++++
 tb/tb_vga_button_conditioner.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_button_conditioner_pkg.sv
// Shared definitions for the VGA button conditioner: button bit indices,
// default timing constants (50 MHz sysclk) and the auto-repeat state type.
package vga_button_conditioner_pkg;

  localparam int BTN_E = 0;
  localparam int BTN_W = 1;
  localparam int BTN_N = 2;
  localparam int BTN_S = 3;
  localparam int BTN_F = 4;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_RATE     = 5000000;
  localparam int DEF_CNT_W           = 25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

endpackage

// File: rtl/vga_button_conditioner_debounce_channel.sv
// One button channel: two-flop synchroniser, stability-count debounce and
// a registered press strobe. The next debounced level is exported so the
// repeat logic can act in the same cycle that the level changes.
module debounce_channel
  import vga_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic sysclk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic level_next,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Accept the synchronised input only after it has differed for the full window
  always_comb begin
    cnt_next   = '0;
    level_next = level;
    if (sync2 == level) begin
      cnt_next = '0;
    end else if (cnt == CNT_LAST) begin
      level_next = sync2;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt + CNT_ONE;
    end
  end

  assign rise = level_next & ~level;

  // Synchroniser, debounce state and press strobe registers
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cnt   <= cnt_next;
      level <= level_next;
      press <= rise;
    end
  end

endmodule

// File: rtl/vga_button_conditioner.sv
// Conditions the raw board buttons for vgadriver: debounced levels, press
// strobes, per-direction auto-repeat movement strobes and a func toggle.
module vga_button_conditioner
  import vga_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       East,
  input  logic       West,
  input  logic       North,
  input  logic       South,
  input  logic       func_switch,
  output logic [4:0] btn_state,
  output logic [4:0] btn_press,
  output logic [3:0] dir_step,
  output logic       func_mode
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] RC_ONE     = CNT_W'(1);

  logic [4:0] raw;
  logic [4:0] level_next;
  logic [4:0] rise;
  logic       unused_func;

  assign raw[BTN_E] = East;
  assign raw[BTN_W] = West;
  assign raw[BTN_N] = North;
  assign raw[BTN_S] = South;
  assign raw[BTN_F] = func_switch;

  // func has no auto-repeat, so its look-ahead signals go nowhere
  assign unused_func = level_next[BTN_F] ^ rise[BTN_F];

  for (genvar i = 0; i < 5; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .sysclk    (sysclk),
      .reset     (reset),
      .raw       (raw[i]),
      .level     (btn_state[i]),
      .press     (btn_press[i]),
      .level_next(level_next[i]),
      .rise      (rise[i])
    );
  end

  for (genvar d = 0; d < 4; d++) begin : g_repeat
    repeat_state_t    state;
    repeat_state_t    state_next;
    logic [CNT_W-1:0] rc;
    logic [CNT_W-1:0] rc_next;
    logic             step;
    logic             step_next;

    // Release (next level low) overrides everything, including a terminal count
    always_comb begin
      state_next = state;
      rc_next    = rc;
      step_next  = 1'b0;
      if (!level_next[d]) begin
        state_next = IDLE;
        rc_next    = '0;
      end else begin
        case (state)
          IDLE: begin
            rc_next = '0;
            if (rise[d]) begin
              step_next  = 1'b1;
              state_next = DELAY;
            end else begin
              state_next = IDLE;
            end
          end
          DELAY: begin
            if (rc == DELAY_LAST) begin
              step_next  = 1'b1;
              rc_next    = '0;
              state_next = REPEAT;
            end else begin
              rc_next = rc + RC_ONE;
            end
          end
          REPEAT: begin
            if (rc == RATE_LAST) begin
              step_next = 1'b1;
              rc_next   = '0;
            end else begin
              rc_next = rc + RC_ONE;
            end
          end
          default: begin
            state_next = IDLE;
            rc_next    = '0;
          end
        endcase
      end
    end

    // Repeat state, counter and registered movement strobe
    always_ff @(posedge sysclk) begin
      if (reset) begin
        state <= IDLE;
        rc    <= '0;
        step  <= 1'b0;
      end else begin
        state <= state_next;
        rc    <= rc_next;
        step  <= step_next;
      end
    end

    assign dir_step[d] = step;
  end

  // func_mode flips the cycle after each debounced func press
  always_ff @(posedge sysclk) begin
    if (reset) begin
      func_mode <= 1'b0;
    end else begin
      func_mode <= func_mode ^ btn_press[BTN_F];
    end
  end

endmodule

// File: tb/tb_vga_button_conditioner.sv
// Self-checking bench: expected press/step cycles are queued as stimulus is
// driven and compared each cycle against the DUT strobes.
module tb_vga_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam int LAT = D + 2;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       East = 1'b0, West = 1'b0, North = 1'b0, South = 1'b0, func_switch = 1'b0;
  logic [4:0] btn_state, btn_press;
  logic [3:0] dir_step;
  logic       func_mode;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int press_q[$];
  int step_q[$];

  vga_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (25)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .East       (East),
    .West       (West),
    .North      (North),
    .South      (South),
    .func_switch(func_switch),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .dir_step   (dir_step),
    .func_mode  (func_mode)
  );

  always #10 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Scoreboard consumer: keys are cycle*8 + bit, kept in ascending order
  always @(negedge sysclk) begin : scoreboard
    int   key;
    logic exp_bit;
    while (press_q.size() > 0 && press_q[0] < cyc * 8) begin
      checks++; errors++;
      $display("FAIL press_stale: expected key %0d never consumed (cycle %0d)", press_q.pop_front(), cyc);
    end
    while (step_q.size() > 0 && step_q[0] < cyc * 8) begin
      checks++; errors++;
      $display("FAIL step_stale: expected key %0d never consumed (cycle %0d)", step_q.pop_front(), cyc);
    end
    for (int b = 0; b < 5; b++) begin
      key = cyc * 8 + b;
      exp_bit = (press_q.size() > 0 && press_q[0] == key);
      if (exp_bit) void'(press_q.pop_front());
      checks++;
      if (btn_press[b] !== exp_bit) begin
        errors++;
        $display("FAIL press_sb: btn_press[%0d]=%b expected %b at cycle %0d", b, btn_press[b], exp_bit, cyc);
      end
    end
    for (int d = 0; d < 4; d++) begin
      key = cyc * 8 + d;
      exp_bit = (step_q.size() > 0 && step_q[0] == key);
      if (exp_bit) void'(step_q.pop_front());
      checks++;
      if (dir_step[d] !== exp_bit) begin
        errors++;
        $display("FAIL step_sb: dir_step[%0d]=%b expected %b at cycle %0d", d, dir_step[d], exp_bit, cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sysclk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    checks++;
    if (btn_state !== 5'b00000 || btn_press !== 5'b00000 || dir_step !== 4'b0000 || func_mode !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: state=%b press=%b step=%b func=%b expected all 0",
               btn_state, btn_press, dir_step, func_mode);
    end
    reset = 1'b0;
    repeat (3) @(negedge sysclk);
  endtask

  task automatic test_hold_repeat();
    int t0, p, rel, fall;
    @(negedge sysclk);
    North = 1'b1; t0 = cyc; p = t0 + LAT;
    rel = t0 + RD + 4 * RR; fall = rel + LAT;
    press_q.push_back(p * 8 + 2);
    step_q.push_back(p * 8 + 2);
    for (int r = p + RD; r < fall; r += RR) step_q.push_back(r * 8 + 2);
    wait_until(p - 1);
    checks++;
    if (btn_state !== 5'b00000) begin
      errors++; $display("FAIL hold_before: btn_state=%b expected 00000 at cycle %0d", btn_state, cyc);
    end
    wait_until(p);
    checks++;
    if (btn_state !== 5'b00100) begin
      errors++; $display("FAIL hold_state: btn_state=%b expected 00100 at cycle %0d", btn_state, cyc);
    end
    wait_until(rel);
    North = 1'b0;
    wait_until(fall - 1);
    checks++;
    if (btn_state !== 5'b00100) begin
      errors++; $display("FAIL hold_pre_release: btn_state=%b expected 00100 at cycle %0d", btn_state, cyc);
    end
    wait_until(fall);
    checks++;
    if (btn_state !== 5'b00000) begin
      errors++; $display("FAIL hold_release: btn_state=%b expected 00000 at cycle %0d", btn_state, cyc);
    end
    wait_until(fall + RR + 4);
    checks++;
    if (press_q.size() != 0 || step_q.size() != 0) begin
      errors++; $display("FAIL hold_drain: %0d press / %0d step left, expected 0", press_q.size(), step_q.size());
    end
  endtask

  task automatic test_glitch();
    int t0, t1, p;
    @(negedge sysclk);
    East = 1'b1; t0 = cyc;
    wait_until(t0 + D - 1);
    East = 1'b0;
    for (int c = t0; c < t0 + 15; c++) begin
      wait_until(c);
      checks++;
      if (btn_state !== 5'b00000) begin
        errors++; $display("FAIL glitch_state: btn_state=%b expected 00000 at cycle %0d", btn_state, cyc);
      end
    end
    t1 = cyc; East = 1'b1; p = t1 + LAT;
    press_q.push_back(p * 8 + 0);
    step_q.push_back(p * 8 + 0);
    wait_until(t1 + D);
    East = 1'b0;
    wait_until(p);
    checks++;
    if (btn_state !== 5'b00001) begin
      errors++; $display("FAIL min_pulse_state: btn_state=%b expected 00001 at cycle %0d", btn_state, cyc);
    end
    wait_until(t1 + D + LAT);
    checks++;
    if (btn_state !== 5'b00000) begin
      errors++; $display("FAIL min_pulse_release: btn_state=%b expected 00000 at cycle %0d", btn_state, cyc);
    end
    wait_until(p + RD + 4);
  endtask

  task automatic test_release_in_delay();
    int t0, p;
    @(negedge sysclk);
    South = 1'b1; t0 = cyc; p = t0 + LAT;
    press_q.push_back(p * 8 + 3);
    step_q.push_back(p * 8 + 3);
    wait_until(t0 + 14);
    South = 1'b0;
    wait_until(t0 + 14 + LAT);
    checks++;
    if (btn_state !== 5'b00000) begin
      errors++; $display("FAIL delay_release: btn_state=%b expected 00000 at cycle %0d", btn_state, cyc);
    end
    wait_until(p + RD + RR + 4);
    // release lands exactly on the DELAY terminal count: no second strobe
    t0 = cyc; South = 1'b1; p = t0 + LAT;
    press_q.push_back(p * 8 + 3);
    step_q.push_back(p * 8 + 3);
    wait_until(t0 + RD);
    South = 1'b0;
    wait_until(p + RD + RR + 4);
    checks++;
    if (step_q.size() != 0 || btn_state !== 5'b00000) begin
      errors++; $display("FAIL delay_drain: %0d step left, btn_state=%b, expected 0 and 00000", step_q.size(), btn_state);
    end
  endtask

  task automatic test_func();
    int t0, t1;
    @(negedge sysclk);
    func_switch = 1'b1; t0 = cyc; t1 = t0 + 20;
    press_q.push_back((t0 + LAT) * 8 + 4);
    press_q.push_back((t1 + LAT) * 8 + 4);
    wait_until(t0 + LAT);
    checks++;
    if (func_mode !== 1'b0) begin
      errors++; $display("FAIL func_first_pre: func_mode=%b expected 0 at cycle %0d", func_mode, cyc);
    end
    wait_until(t0 + LAT + 1);
    checks++;
    if (func_mode !== 1'b1) begin
      errors++; $display("FAIL func_first_toggle: func_mode=%b expected 1 at cycle %0d", func_mode, cyc);
    end
    wait_until(t0 + 10);
    func_switch = 1'b0;
    wait_until(t1);
    func_switch = 1'b1;
    wait_until(t1 + LAT);
    checks++;
    if (func_mode !== 1'b1) begin
      errors++; $display("FAIL func_second_pre: func_mode=%b expected 1 at cycle %0d", func_mode, cyc);
    end
    wait_until(t1 + LAT + 1);
    checks++;
    if (func_mode !== 1'b0) begin
      errors++; $display("FAIL func_second_toggle: func_mode=%b expected 0 at cycle %0d", func_mode, cyc);
    end
    wait_until(t1 + 10);
    func_switch = 1'b0;
    wait_until(t1 + 10 + LAT + 4);
  endtask

  task automatic test_reset_midrun();
    int t0, p, r, p2;
    @(negedge sysclk);
    North = 1'b1; t0 = cyc; p = t0 + LAT; r = p + RD + RR + 2;
    press_q.push_back(p * 8 + 2);
    step_q.push_back(p * 8 + 2);
    step_q.push_back((p + RD) * 8 + 2);
    step_q.push_back((p + RD + RR) * 8 + 2);
    wait_until(r);
    reset = 1'b1;
    wait_until(r + 1);
    reset = 1'b0;
    checks++;
    if (btn_state !== 5'b00000 || btn_press !== 5'b00000 || dir_step !== 4'b0000 || func_mode !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: state=%b press=%b step=%b func=%b expected all 0",
               btn_state, btn_press, dir_step, func_mode);
    end
    p2 = r + 1 + LAT;
    press_q.push_back(p2 * 8 + 2);
    step_q.push_back(p2 * 8 + 2);
    wait_until(p2 - 1);
    checks++;
    if (btn_state !== 5'b00000) begin
      errors++; $display("FAIL midrun_relatch_pre: btn_state=%b expected 00000 at cycle %0d", btn_state, cyc);
    end
    wait_until(p2 + 3);
    North = 1'b0;
    wait_until(p2 + RD + 4);
  endtask

  task automatic test_back_to_back_dirs();
    int t0, p, fall;
    @(negedge sysclk);
    East = 1'b1; West = 1'b1; t0 = cyc; p = t0 + LAT; fall = t0 + 30 + LAT;
    press_q.push_back(p * 8 + 0);
    press_q.push_back(p * 8 + 1);
    step_q.push_back(p * 8 + 0);
    step_q.push_back(p * 8 + 1);
    for (int s = p + RD; s < fall; s += RR) begin
      step_q.push_back(s * 8 + 0);
      step_q.push_back(s * 8 + 1);
    end
    wait_until(p);
    checks++;
    if (btn_state !== 5'b00011) begin
      errors++; $display("FAIL dual_state: btn_state=%b expected 00011 at cycle %0d", btn_state, cyc);
    end
    wait_until(t0 + 30);
    East = 1'b0; West = 1'b0;
    wait_until(fall + RR + 4);
    checks++;
    if (press_q.size() != 0 || step_q.size() != 0 || btn_state !== 5'b00000) begin
      errors++; $display("FAIL dual_drain: %0d press / %0d step left, btn_state=%b, expected 0/0/00000",
                         press_q.size(), step_q.size(), btn_state);
    end
  endtask

  initial begin
    test_reset();
    test_hold_repeat();
    test_glitch();
    test_release_in_delay();
    test_func();
    test_reset_midrun();
    test_back_to_back_dirs();
    repeat (2) @(negedge sysclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
